// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation for load-use
// hazards, multi-cycle EX operations and MEM redirects, plus a stall counter.
module pipe_ctrl #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              ex_start,
   input  logic [CNT_W-1:0]  ex_cycles,
   input  logic              flush_req,
   output logic [5:0]        stall,
   output logic              flush,
   output logic              ex_done,
   output logic              busy,
   output logic [PERF_W-1:0] stall_cycles
);

   typedef enum logic {
      IDLE    = 1'b0,
      EX_WAIT = 1'b1
   } state_t;

   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PERF_W-1:0]  perf_q, perf_d;
   logic               ex_valid;

   // An ex_start with a zero cycle count is not an operation at all.
   assign ex_valid = ex_start && (ex_cycles != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = '0;
      flush   = 1'b0;
      ex_done = 1'b0;

      if (flush_req) begin
         flush   = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == EX_WAIT) begin
         stall = STALL_EX;
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q <= CNT_W'(1)) begin
            ex_done = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else if (ex_valid) begin
         stall = STALL_EX;
         if (ex_cycles == CNT_W'(1)) begin
            ex_done = 1'b1;
         end else begin
            state_d = EX_WAIT;
            cnt_d   = ex_cycles - CNT_W'(1);
         end
      end else if (stallreq_id) begin
         stall = STALL_ID;
      end
   end

   always_comb begin
      perf_d = perf_q;
      if ((stall != '0) && !(&perf_q)) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

   assign busy         = (state_q == EX_WAIT);
   assign stall_cycles = perf_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 6: width of ex_cycles and of the internal cycle counter.
REQ-002 Parameter PERF_W, default 16: width of the stall_cycles performance counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high (1 = reset asserted, sampled on posedge clk).
REQ-005 stallreq_id  input  1  load-use hazard from ID; request a stall this cycle.
REQ-006 ex_start  input  1  EX begins a multi-cycle op (mult-acc, div); qualifies ex_cycles.
REQ-007 ex_cycles  input  CNT_W  total stall cycles required by the op (N); 0 = no stall.
REQ-008 flush_req  input  1  exception/redirect from MEM; kill the pipeline.
REQ-009 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-010 flush  output  1  clear all pipeline registers to NOP this cycle.
REQ-011 ex_done  output  1  one-cycle pulse on the last stall cycle of a multi-cycle op.
REQ-012 busy  output  1  high while in EX_WAIT.
REQ-013 stall_cycles  output  PERF_W  count of cycles with stall != 0, saturating.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and EX_WAIT, plus a CNT_W-bit down-counter cnt.
REQ-015 stall, flush and ex_done SHALL be combinational from the state, cnt and the current-cycle inputs (zero-latency response); state, cnt and stall_cycles SHALL be registered.
REQ-016 Priority per cycle SHALL be flush_req > EX stall > stallreq_id.
REQ-017 flush_req=1 (any state): flush=1, stall=6'b000000, ex_done=0, next state IDLE, cnt<=0; ex_start and stallreq_id are ignored that cycle.
REQ-018 IDLE, no flush, ex_start=1, ex_cycles=N>=1: stall=6'b001111 this cycle; if N=1, ex_done=1 and the block stays in IDLE; if N>=2, next state is EX_WAIT with cnt<=N-1.
REQ-019 IDLE, no flush, ex_start=1, ex_cycles=0: ex_start SHALL be treated as absent (no stall, no ex_done).
REQ-020 IDLE, no flush, no effective ex_start: stall=6'b000111 if stallreq_id=1, else 6'b000000.
REQ-021 EX_WAIT, no flush: stall=6'b001111 and busy=1; cnt<=cnt-1; when cnt==1, ex_done=1 and next state is IDLE.
REQ-022 In EX_WAIT, ex_start and stallreq_id SHALL be ignored (the EX stall covers the ID stall).
REQ-023 A multi-cycle op with N>=1 and no flush SHALL produce exactly N consecutive cycles of stall=6'b001111 and exactly one ex_done pulse, coincident with the Nth cycle.
REQ-024 ex_done SHALL never be asserted in the same cycle as flush.
REQ-025 stall_cycles SHALL increment by 1 on each posedge where stall != 0 in that cycle, and SHALL hold at all-ones (no wrap).
REQ-026 flush SHALL NOT clear stall_cycles.
REQ-027 busy SHALL equal (state == EX_WAIT) and is registered-state derived only.

Reset
REQ-028 While rst=1 at posedge clk: state<=IDLE, cnt<=0, stall_cycles<=0.
REQ-029 Reset SHALL take effect in the same edge regardless of state, aborting any EX_WAIT without issuing ex_done.
REQ-030 During a cycle with state=IDLE after reset and all inputs 0: stall=0, flush=0, ex_done=0, busy=0.

Verification
REQ-031 Reset, then idle 3 cycles -> stall=000000, flush=0, busy=0, stall_cycles=0.
REQ-032 stallreq_id=1 for 2 cycles in IDLE -> stall=000111 both cycles, then 000000; stall_cycles=2.
REQ-033 ex_start=1, ex_cycles=4 at cycle T -> stall=001111 for T..T+3, ex_done only at T+3, busy at T+1..T+3, stall=000000 at T+4; stall_cycles=4.
REQ-034 ex_start with ex_cycles=5, flush_req=1 at T+2 -> stall=000000, flush=1 at T+2, no ex_done, busy=0 from T+3; simultaneous flush_req+ex_start in IDLE -> no stall, stays IDLE.
REQ-035 ex_start with ex_cycles=1 together with stallreq_id=1 -> stall=001111, ex_done=1 same cycle, busy never 1; ex_cycles=0 with stallreq_id=1 -> stall=000111.
REQ-036 rst asserted mid EX_WAIT (cnt=3) -> next cycle IDLE, busy=0, no ex_done, stall_cycles=0; force 2^PERF_W+5 stall cycles -> stall_cycles saturates at all-ones.
